// File: rtl/comp_serial_nbit_pkg.sv
// Shared definitions for the bit-serial magnitude comparator:
// FSM state encoding and the {l,e,g} result codes.
package comp_serial_nbit_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Result codes are packed as {l, e, g}
  localparam logic [2:0] RES_L = 3'b100;
  localparam logic [2:0] RES_E = 3'b010;
  localparam logic [2:0] RES_G = 3'b001;

  function automatic logic [2:0] res_code(input logic lt, input logic gt);
    if (lt)      return RES_L;
    else if (gt) return RES_G;
    else         return RES_E;
  endfunction

endpackage

// File: rtl/comp_serial_nbit_cell.sv
// One-bit compare cell built from 2:1 muxes; inv flips the sense of ai
// so the signed sign bit can reuse the same cell.
module mux_2x1 (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

module bit_cmp_cell (
  input  logic ai,
  input  logic bi,
  input  logic inv,
  output logic lt,
  output logic eq,
  output logic gt
);
  logic diff;
  logic a_eff;

  // diff = ai ^ bi, a_eff = ai ^ inv, each as a single mux
  mux_2x1 u_diff (.d0(bi), .d1(~bi), .sel(ai),  .y(diff));
  mux_2x1 u_aeff (.d0(ai), .d1(~ai), .sel(inv), .y(a_eff));

  assign eq = ~diff;
  assign gt = diff & a_eff;
  assign lt = diff & ~a_eff;
endmodule

// File: rtl/comp_serial_nbit.sv
// Bit-serial MSB-first magnitude comparator with start/done handshake,
// signed/unsigned modes and optional early exit on the first differing bit.
module comp_serial_nbit
  import comp_serial_nbit_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             e,
  output logic             g
);

  localparam int IW = $clog2(WIDTH);
  localparam logic [IW-1:0] TOP_IDX = IW'(WIDTH - 1);

  state_t           state, state_nx;
  logic [WIDTH-1:0] a_q, b_q;
  logic             sm_q;
  logic [IW-1:0]    idx, idx_nx;
  logic             found_q, found_nx;
  logic [2:0]       rec_q, rec_nx;
  logic [2:0]       res_q, res_nx;
  logic             busy_nx, done_nx, latch_en;
  logic             bit_lt, bit_eq, bit_gt;
  logic [2:0]       bit_res;

  bit_cmp_cell u_cell (
    .ai  (a_q[idx]),
    .bi  (b_q[idx]),
    .inv (sm_q && (idx == TOP_IDX)),
    .lt  (bit_lt),
    .eq  (bit_eq),
    .gt  (bit_gt)
  );

  assign bit_res = res_code(bit_lt, bit_gt);

  // Without early exit the MSB-most difference is remembered and wins at index 0
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    found_nx = found_q;
    rec_nx   = rec_q;
    res_nx   = res_q;
    busy_nx  = busy;
    done_nx  = 1'b0;
    latch_en = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          latch_en = 1'b1;
          idx_nx   = TOP_IDX;
          found_nx = 1'b0;
          rec_nx   = RES_E;
          busy_nx  = 1'b1;
          state_nx = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!found_q && !bit_eq) begin
          found_nx = 1'b1;
          rec_nx   = bit_res;
        end
        if ((EARLY_EXIT && !bit_eq) || (idx == '0)) begin
          res_nx   = found_q ? rec_q : bit_res;
          done_nx  = 1'b1;
          busy_nx  = 1'b0;
          state_nx = ST_IDLE;
        end else begin
          idx_nx = idx - 1'b1;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= '0;
      found_q <= 1'b0;
      rec_q   <= '0;
      res_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      found_q <= found_nx;
      rec_q   <= rec_nx;
      res_q   <= res_nx;
      busy    <= busy_nx;
      done    <= done_nx;
      if (latch_en) begin
        a_q  <= a;
        b_q  <= b;
        sm_q <= signed_mode;
      end
    end
  end

  assign {l, e, g} = res_q;

endmodule

// File: tb/tb_comp_serial_nbit.sv
// Self-checking bench: one early-exit and one fixed-latency comparator,
// checked against an arithmetic reference model with directed and random cases.
module tb_comp_serial_nbit;
  import comp_serial_nbit_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic       signed_mode;
  logic [7:0] a, b;
  logic       busy0, done0, l0, e0, g0;
  logic       busy1, done1, l1, e1, g1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  comp_serial_nbit #(.WIDTH(8), .EARLY_EXIT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy0), .done(done0), .l(l0), .e(e0), .g(g0)
  );

  comp_serial_nbit #(.WIDTH(8), .EARLY_EXIT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .signed_mode(signed_mode),
    .a(a), .b(b), .busy(busy1), .done(done1), .l(l1), .e(e1), .g(g1)
  );

  function automatic logic get_done(input bit ee);
    return ee ? done1 : done0;
  endfunction

  function automatic logic get_busy(input bit ee);
    return ee ? busy1 : busy0;
  endfunction

  function automatic logic [2:0] get_leg(input bit ee);
    return ee ? {l1, e1, g1} : {l0, e0, g0};
  endfunction

  // Reference: plain integer compare, latency from the highest differing bit
  function automatic void model(input logic [7:0] av, input logic [7:0] bv,
                                input bit sm, input bit ee,
                                output logic [2:0] leg, output int k);
    longint sa, sb;
    logic [7:0] x;
    int p;
    sa = sm ? longint'($signed(av)) : longint'(av);
    sb = sm ? longint'($signed(bv)) : longint'(bv);
    leg = (sa < sb) ? 3'b100 : (sa == sb) ? 3'b010 : 3'b001;
    x = av ^ bv;
    p = -1;
    for (int i = 7; i >= 0; i--) begin
      if (x[i] && p < 0) p = i;
    end
    k = (ee && p >= 0) ? (8 - p) : 8;
  endfunction

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a compare at #1 after a posedge and waits (bounded) for done
  task automatic run_cmp(input bit ee, input logic [7:0] av, input logic [7:0] bv,
                         input bit sm, input string tag);
    logic [2:0] exp_leg;
    int exp_k;
    int k;
    model(av, bv, sm, ee, exp_leg, exp_k);
    a = av; b = bv; signed_mode = sm;
    if (ee) start1 = 1'b1; else start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0; start1 = 1'b0;
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (get_done(ee)) break;
    end
    check_output({tag, " done"}, 8'(get_done(ee)), 8'd1);
    check_output({tag, " latency"}, 8'(k), 8'(exp_k));
    check_output({tag, " leg"}, 8'(get_leg(ee)), 8'(exp_leg));
    check_output({tag, " busy"}, 8'(get_busy(ee)), 8'd0);
    @(posedge clk); #1;
    check_output({tag, " pulse"}, 8'(get_done(ee)), 8'd0);
    check_output({tag, " hold"}, 8'(get_leg(ee)), 8'(exp_leg));
  endtask

  initial begin
    logic [2:0] exp_leg;
    int exp_k;
    int k;
    int saw_done;
    logic [7:0] ra, rb;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; signed_mode = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset dut0", 8'({busy0, done0, l0, e0, g0}), 8'd0);
    check_output("reset dut1", 8'({busy1, done1, l1, e1, g1}), 8'd0);
    rst = 1'b0;

    run_cmp(1'b1, 8'h80, 8'h7F, 1'b0, "ee1 u 80/7f");
    run_cmp(1'b1, 8'h5A, 8'h5A, 1'b0, "ee1 u eq 5a");
    run_cmp(1'b1, 8'h80, 8'h7F, 1'b1, "ee1 s 80/7f");
    run_cmp(1'b0, 8'h80, 8'h7F, 1'b1, "ee0 s 80/7f");
    run_cmp(1'b0, 8'hC0, 8'h80, 1'b0, "ee0 u c0/80");
    run_cmp(1'b0, 8'h01, 8'h00, 1'b1, "ee0 s lsb");
    run_cmp(1'b1, 8'hFF, 8'h00, 1'b1, "ee1 s ff/00");

    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
        default: rb = 8'($urandom);
      endcase
      run_cmp(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), "random");
    end

    // start while busy is ignored; start in the done cycle is accepted
    a = 8'h5A; b = 8'h5A; signed_mode = 1'b0; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 8'h00; b = 8'hFF; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 3;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done1) break;
    end
    check_output("busy-start latency", 8'(k), 8'd8);
    check_output("busy-start leg", 8'({l1, e1, g1}), 8'(RES_E));
    a = 8'h10; b = 8'h20; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    check_output("b2b busy", 8'({busy1, done1}), 8'b10);
    check_output("b2b hold", 8'({l1, e1, g1}), 8'(RES_E));
    model(8'h10, 8'h20, 1'b0, 1'b1, exp_leg, exp_k);
    k = 0;
    while (k < 40) begin
      @(posedge clk); #1;
      k++;
      if (done1) break;
    end
    check_output("b2b latency", 8'(k), 8'(exp_k));
    check_output("b2b leg", 8'({l1, e1, g1}), 8'(exp_leg));

    // reset three cycles into a run aborts without a done pulse
    a = 8'h33; b = 8'h33; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_output("rst midrun", 8'({busy1, done1, l1, e1, g1}), 8'd0);
    rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done1) saw_done++;
    end
    check_output("rst no done", 8'(saw_done), 8'd0);

    // reset wins over start in the same cycle
    rst = 1'b1; start1 = 1'b1; a = 8'h01; b = 8'h02;
    @(posedge clk); #1;
    check_output("rst vs start", 8'({busy1, done1}), 8'd0);
    rst = 1'b0; start1 = 1'b0;
    run_cmp(1'b1, 8'h01, 8'h02, 1'b0, "after rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
